bus_interface_ctrl: RTL and testbench
=====================================

// Module: bus_interface_ctrl
// PURPOSE
//  Parametrised bus interface unit between the decode/EU side and the GPR file and data RAM.
//  Executes one bus operation per start:
//   - register move, immediate load, RAM load/store, EU operand fetch, EU result writeback.
//  Uses point-to-point req/ack channels with split read/write data; no tristate bus.
//  Adds an ack timeout with error reporting.
// PARAMETERS
//  DW       16  data width (GPR and RAM words)
//  RAW       3  GPR index width (2**RAW registers)
//  AW       16  RAM word-address width
//  TIMEOUT  16  max cycles a req may wait for ack; 0 disables the timeout
// PORTS
//  clk        in   1    clock, all state on rising edge
//  rst        in   1    asynchronous active-high reset
//  start      in   1    launch operation; sampled only in IDLE
//  op         in   3    000 MOV, 001 MOVI, 010 LOAD, 011 STORE, 100 FETCH2, 101 WB, others illegal
//  rd/rs1/rs2 in   RAW  destination / source register indices
//  mem_addr   in   AW   RAM word address (LOAD/STORE)
//  imm        in   DW   immediate (MOVI)
//  eu_result  in   DW   EU result (WB)
//  busy       out  1    high in every state except IDLE
//  done       out  1    one-cycle completion pulse
//  err        out  1    with done: illegal op or timeout
//  op_a/op_b  out  DW   operands from FETCH2; held until the next FETCH2 completes
//  gpr_req    out  1    GPR request
//  gpr_we     out  1    GPR write (1) / read (0)
//  gpr_addr   out  RAW  GPR register index
//  gpr_wdata  out  DW   GPR write data
//  gpr_rdata  in   DW   GPR read data
//  gpr_ack    in   1    GPR acknowledge
//  ram_req    out  1    RAM request
//  ram_we     out  1    RAM write (1) / read (0)
//  ram_addr   out  AW   RAM word address
//  ram_wdata  out  DW   RAM write data
//  ram_rdata  in   DW   RAM read data
//  ram_ack    in   1    RAM acknowledge
// BEHAVIOUR
//  Reset: every output 0, FSM to IDLE, internal data register (mbr) and timeout counter cleared.
//  Reset mid-operation: requests drop immediately; no done pulse.
//  On start in IDLE: latch op, rd, rs1, rs2, mem_addr, imm, eu_result; ignore inputs until IDLE.
//  start while busy: ignored; not queued.
//  Handshake:
//   - req, we, addr and wdata are registered; they stay stable while req=1.
//   - A transfer completes on the rising edge where req=1 and ack=1.
//   - req drops on the next cycle unless the next state issues a new request.
//   - Read data is captured into mbr (or op_a/op_b) on the ack edge.
//   - Only one channel is requested at a time.
//  States and sequences:
//   IDLE  -> start: state per op below; illegal op goes to DONE with err=1
//   MOV    GRD(rs1) -> GWR(rd, mbr) -> DONE
//   MOVI   GWR(rd, imm) -> DONE
//   LOAD   RRD(mem_addr) -> GWR(rd, mbr) -> DONE
//   STORE  GRD(rs1) -> RWR(mem_addr, mbr) -> DONE
//   FETCH2 GRD(rs1)->op_a -> GRD2(rs2)->op_b -> DONE
//   WB     GWR(rd, eu_result) -> DONE
//   DONE: done=1 for one cycle, err as set -> IDLE (busy=0 in the following cycle)
//  Latency with zero-wait ack: done asserts N+1 cycles after the start edge, N = bus transfers.
//   - MOVI/WB: 2 cycles. MOV/LOAD/STORE/FETCH2: 3 cycles.
//   - Each wait cycle adds 1.
//  Timeout:
//   - Counter clears at each new req and counts cycles with req=1, ack=0.
//   - Reaching TIMEOUT: drop req, go to DONE, err=1; op_a/op_b not updated.
//  err clears when DONE exits; it never asserts without done.
//  Same-register MOV (rd==rs1): normal read then write; no shortcut.
// TESTING
//  - Reset: rst pulse mid-LOAD with ram_req=1 -> ram_req=0 immediately; busy=0; no done.
//  - MOVI rd=3 imm=16'hA5A5, zero-wait ack -> gpr_we=1 gpr_addr=3 gpr_wdata=A5A5; done 2 cycles after start.
//  - FETCH2 rs1=1 (=16'h0012), rs2=2 (=16'h0034), GPR ack delayed 2 cycles each
//    -> op_a=0012, op_b=0034; done at start+7.
//  - LOAD mem_addr=16'h0100 (RAM=16'hBEEF) rd=5 then STORE rs1=5 mem_addr=16'h0200
//    -> RAM[0200]=BEEF; start asserted while busy has no effect.
//  - RAM never acks, TIMEOUT=16: ram_req high 16 cycles then drops; done=1, err=1; GPR untouched.
//  - op=3'b111 -> done=1 err=1 one cycle after start; no gpr_req/ram_req asserted.

Source files
------------

// File: rtl/bus_interface_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : bus_interface_ctrl_if
//  Description : Point-to-point req/ack channels from the bus interface unit
//                to the GPR file and to the data RAM. Split read/write data,
//                no tristates.
//                  gpr_req/gpr_we/gpr_addr/gpr_wdata : controller -> GPR file
//                  gpr_rdata/gpr_ack                 : GPR file -> controller
//                  ram_req/ram_we/ram_addr/ram_wdata : controller -> RAM
//                  ram_rdata/ram_ack                 : RAM -> controller
//                Modports: master (controller side), slave (GPR/RAM side).
//  Revision    : 1.0 - initial release
// ============================================================================
interface bus_interface_ctrl_if #(
    parameter int unsigned DW  = 16,
    parameter int unsigned RAW = 3,
    parameter int unsigned AW  = 16
);
    logic           gpr_req;
    logic           gpr_we;
    logic [RAW-1:0] gpr_addr;
    logic [DW-1:0]  gpr_wdata;
    logic [DW-1:0]  gpr_rdata;
    logic           gpr_ack;

    logic           ram_req;
    logic           ram_we;
    logic [AW-1:0]  ram_addr;
    logic [DW-1:0]  ram_wdata;
    logic [DW-1:0]  ram_rdata;
    logic           ram_ack;

    modport master (
        output gpr_req, gpr_we, gpr_addr, gpr_wdata,
        input  gpr_rdata, gpr_ack,
        output ram_req, ram_we, ram_addr, ram_wdata,
        input  ram_rdata, ram_ack
    );

    modport slave (
        input  gpr_req, gpr_we, gpr_addr, gpr_wdata,
        output gpr_rdata, gpr_ack,
        input  ram_req, ram_we, ram_addr, ram_wdata,
        output ram_rdata, ram_ack
    );
endinterface
`default_nettype wire

// File: rtl/bus_interface_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : bus_interface_ctrl
//  Description : Bus interface unit between decode/EU and the GPR file / RAM.
//                Runs one bus operation per start: MOV, MOVI, LOAD, STORE,
//                FETCH2 (two operand reads), WB (EU result writeback).
//                An ack timeout aborts a stalled transfer with err.
//  Ports       : clk, rst           clock / async active-high reset
//                start_i, op_i      launch + opcode (sampled only in IDLE)
//                rd_i, rs1_i, rs2_i register indices
//                mem_addr_i, imm_i, eu_result_i  operation operands
//                busy_o, done_o, err_o           status
//                op_a_o, op_b_o     FETCH2 operands, held until next FETCH2
//                bus                GPR and RAM req/ack channels (master)
//  Revision    : 1.0 - initial release
// ============================================================================
module bus_interface_ctrl #(
    parameter int unsigned DW      = 16,
    parameter int unsigned RAW     = 3,
    parameter int unsigned AW      = 16,
    parameter int unsigned TIMEOUT = 16
) (
    input  wire logic           clk,
    input  wire logic           rst,
    input  wire logic           start_i,
    input  wire logic [2:0]     op_i,
    input  wire logic [RAW-1:0] rd_i,
    input  wire logic [RAW-1:0] rs1_i,
    input  wire logic [RAW-1:0] rs2_i,
    input  wire logic [AW-1:0]  mem_addr_i,
    input  wire logic [DW-1:0]  imm_i,
    input  wire logic [DW-1:0]  eu_result_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                err_o,
    output logic [DW-1:0]       op_a_o,
    output logic [DW-1:0]       op_b_o,
    bus_interface_ctrl_if.master bus
);

    localparam logic [2:0] c_OP_MOV    = 3'b000;
    localparam logic [2:0] c_OP_MOVI   = 3'b001;
    localparam logic [2:0] c_OP_LOAD   = 3'b010;
    localparam logic [2:0] c_OP_STORE  = 3'b011;
    localparam logic [2:0] c_OP_FETCH2 = 3'b100;
    localparam logic [2:0] c_OP_WB     = 3'b101;

    // Counter holds the number of wait cycles already spent; the abort fires
    // on the cycle that would make it reach TIMEOUT.
    localparam int unsigned       CW          = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0]     c_TO_LAST   = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_GRD  = 3'd1,
        S_GRD2 = 3'd2,
        S_GWR  = 3'd3,
        S_RRD  = 3'd4,
        S_RWR  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t         state_q, state_d;
    logic           err_q, err_d;
    logic [DW-1:0]  mbr_q, mbr_d;
    logic [DW-1:0]  op_a_q, op_a_d;
    logic [DW-1:0]  op_b_q, op_b_d;
    logic [CW-1:0]  cnt_q, cnt_d;

    logic [2:0]     op_q, op_d;
    logic [RAW-1:0] rd_q, rd_d;
    logic [RAW-1:0] rs1_q, rs1_d;
    logic [RAW-1:0] rs2_q, rs2_d;
    logic [AW-1:0]  maddr_q, maddr_d;
    logic [DW-1:0]  imm_q, imm_d;
    logic [DW-1:0]  eu_q, eu_d;

    logic           gpr_req_q, gpr_req_d;
    logic           gpr_we_q, gpr_we_d;
    logic [RAW-1:0] gpr_addr_q, gpr_addr_d;
    logic [DW-1:0]  gpr_wdata_q, gpr_wdata_d;
    logic           ram_req_q, ram_req_d;
    logic           ram_we_q, ram_we_d;
    logic [AW-1:0]  ram_addr_q, ram_addr_d;
    logic [DW-1:0]  ram_wdata_q, ram_wdata_d;

    logic           w_gpr_xfer;
    logic           w_ram_xfer;
    logic           w_req;
    logic           w_xfer;
    logic           w_timeout;

    assign w_gpr_xfer = gpr_req_q & bus.gpr_ack;
    assign w_ram_xfer = ram_req_q & bus.ram_ack;
    assign w_req      = gpr_req_q | ram_req_q;
    assign w_xfer     = w_gpr_xfer | w_ram_xfer;
    assign w_timeout  = (TIMEOUT != 0) && w_req && !w_xfer && (cnt_q == c_TO_LAST);

    always_comb begin
        state_d = state_q;
        err_d   = err_q;
        mbr_d   = mbr_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        op_d    = op_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        maddr_d = maddr_q;
        imm_d   = imm_q;
        eu_d    = eu_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    op_d    = op_i;
                    rd_d    = rd_i;
                    rs1_d   = rs1_i;
                    rs2_d   = rs2_i;
                    maddr_d = mem_addr_i;
                    imm_d   = imm_i;
                    eu_d    = eu_result_i;
                    case (op_i)
                        c_OP_MOV, c_OP_STORE, c_OP_FETCH2: state_d = S_GRD;
                        c_OP_MOVI, c_OP_WB:                state_d = S_GWR;
                        c_OP_LOAD:                         state_d = S_RRD;
                        default: begin
                            state_d = S_DONE;
                            err_d   = 1'b1;
                        end
                    endcase
                end
            end
            S_GRD: begin
                if (w_gpr_xfer) begin
                    mbr_d = bus.gpr_rdata;
                    case (op_q)
                        c_OP_MOV:    state_d = S_GWR;
                        c_OP_STORE:  state_d = S_RWR;
                        c_OP_FETCH2: state_d = S_GRD2;
                        default:     state_d = S_DONE;
                    endcase
                end
            end
            S_GRD2: begin
                // Both operands are committed together so a timeout on the
                // second read leaves the previous pair intact.
                if (w_gpr_xfer) begin
                    op_a_d  = mbr_q;
                    op_b_d  = bus.gpr_rdata;
                    state_d = S_DONE;
                end
            end
            S_GWR: begin
                if (w_gpr_xfer) begin
                    state_d = S_DONE;
                end
            end
            S_RRD: begin
                if (w_ram_xfer) begin
                    mbr_d   = bus.ram_rdata;
                    state_d = S_GWR;
                end
            end
            S_RWR: begin
                if (w_ram_xfer) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
        endcase

        if (w_timeout) begin
            state_d = S_DONE;
            err_d   = 1'b1;
        end

        // Any completed transfer (or idle channel) restarts the wait count,
        // so each new request starts from zero.
        if (w_req && !w_xfer) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            cnt_d = '0;
        end

        // Bus outputs are registered from the next state, so back-to-back
        // transfers keep req high and only addr/we/wdata switch.
        gpr_req_d   = (state_d == S_GRD) || (state_d == S_GRD2) || (state_d == S_GWR);
        gpr_we_d    = (state_d == S_GWR);
        gpr_addr_d  = '0;
        gpr_wdata_d = '0;
        case (state_d)
            S_GRD:  gpr_addr_d = rs1_d;
            S_GRD2: gpr_addr_d = rs2_d;
            S_GWR: begin
                gpr_addr_d = rd_d;
                case (op_d)
                    c_OP_MOVI: gpr_wdata_d = imm_d;
                    c_OP_WB:   gpr_wdata_d = eu_d;
                    default:   gpr_wdata_d = mbr_d;
                endcase
            end
            default: gpr_addr_d = '0;
        endcase

        ram_req_d   = (state_d == S_RRD) || (state_d == S_RWR);
        ram_we_d    = (state_d == S_RWR);
        ram_addr_d  = ram_req_d ? maddr_d : '0;
        ram_wdata_d = (state_d == S_RWR) ? mbr_d : '0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            err_q       <= 1'b0;
            mbr_q       <= '0;
            op_a_q      <= '0;
            op_b_q      <= '0;
            cnt_q       <= '0;
            op_q        <= '0;
            rd_q        <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            maddr_q     <= '0;
            imm_q       <= '0;
            eu_q        <= '0;
            gpr_req_q   <= 1'b0;
            gpr_we_q    <= 1'b0;
            gpr_addr_q  <= '0;
            gpr_wdata_q <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            err_q       <= err_d;
            mbr_q       <= mbr_d;
            op_a_q      <= op_a_d;
            op_b_q      <= op_b_d;
            cnt_q       <= cnt_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            maddr_q     <= maddr_d;
            imm_q       <= imm_d;
            eu_q        <= eu_d;
            gpr_req_q   <= gpr_req_d;
            gpr_we_q    <= gpr_we_d;
            gpr_addr_q  <= gpr_addr_d;
            gpr_wdata_q <= gpr_wdata_d;
            ram_req_q   <= ram_req_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
        end
    end

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign err_o         = err_q;
    assign op_a_o        = op_a_q;
    assign op_b_o        = op_b_q;

    assign bus.gpr_req   = gpr_req_q;
    assign bus.gpr_we    = gpr_we_q;
    assign bus.gpr_addr  = gpr_addr_q;
    assign bus.gpr_wdata = gpr_wdata_q;
    assign bus.ram_req   = ram_req_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_wdata = ram_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_bus_interface_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bus_interface_ctrl
//  Description : Self-checking bench for bus_interface_ctrl: directed vector
//                table, hand-written reset/timeout sequences and random
//                operations checked against an operation-level model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_interface_ctrl;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [2:0]  op_i;
    logic [2:0]  rd_i, rs1_i, rs2_i;
    logic [15:0] mem_addr_i, imm_i, eu_result_i;
    logic        busy_o, done_o, err_o;
    logic [15:0] op_a_o, op_b_o;

    bus_interface_ctrl_if #(.DW(16), .RAW(3), .AW(16)) bus ();

    bus_interface_ctrl #(.DW(16), .RAW(3), .AW(16), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_i     (start_i),
        .op_i        (op_i),
        .rd_i        (rd_i),
        .rs1_i       (rs1_i),
        .rs2_i       (rs2_i),
        .mem_addr_i  (mem_addr_i),
        .imm_i       (imm_i),
        .eu_result_i (eu_result_i),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .err_o       (err_o),
        .op_a_o      (op_a_o),
        .op_b_o      (op_b_o),
        .bus         (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- GPR / RAM slaves ----------------
    logic [15:0] s_gpr [0:7];
    logic [15:0] s_ram [0:65535];
    int          gpr_wait, ram_wait;
    bit          gpr_never, ram_never;
    int          gcnt, rcnt;
    bit          bd_we;
    logic [2:0]  bd_ga;
    logic [15:0] bd_gd, bd_ra, bd_rd;

    assign bus.gpr_ack   = bus.gpr_req && !gpr_never && (gcnt >= gpr_wait);
    assign bus.ram_ack   = bus.ram_req && !ram_never && (rcnt >= ram_wait);
    assign bus.gpr_rdata = s_gpr[bus.gpr_addr];
    assign bus.ram_rdata = s_ram[bus.ram_addr];

    always @(posedge clk) begin
        gcnt <= (!bus.gpr_req || bus.gpr_ack) ? 0 : gcnt + 1;
        rcnt <= (!bus.ram_req || bus.ram_ack) ? 0 : rcnt + 1;
        if (bd_we) begin
            s_gpr[bd_ga] <= bd_gd;
            s_ram[bd_ra] <= bd_rd;
        end
        if (bus.gpr_req && bus.gpr_ack && bus.gpr_we) s_gpr[bus.gpr_addr] <= bus.gpr_wdata;
        if (bus.ram_req && bus.ram_ack && bus.ram_we) s_ram[bus.ram_addr] <= bus.ram_wdata;
    end

    // ---------------- protocol monitor ----------------
    int          proto_err;
    logic        p_greq, p_gack, p_rreq, p_rack;
    logic [19:0] p_g;
    logic [32:0] p_r;

    initial begin
        proto_err = 0; gcnt = 0; rcnt = 0;
        p_greq = 1'b0; p_gack = 1'b0; p_rreq = 1'b0; p_rack = 1'b0;
    end

    always @(negedge clk) begin
        if (bus.gpr_req && bus.ram_req) proto_err <= proto_err + 1;
        if (err_o && !done_o) proto_err <= proto_err + 1;
        if (p_greq && !p_gack && bus.gpr_req && ({bus.gpr_we, bus.gpr_addr, bus.gpr_wdata} != p_g))
            proto_err <= proto_err + 1;
        if (p_rreq && !p_rack && bus.ram_req && ({bus.ram_we, bus.ram_addr, bus.ram_wdata} != p_r))
            proto_err <= proto_err + 1;
        p_greq <= bus.gpr_req; p_gack <= bus.gpr_ack;
        p_rreq <= bus.ram_req; p_rack <= bus.ram_ack;
        p_g    <= {bus.gpr_we, bus.gpr_addr, bus.gpr_wdata};
        p_r    <= {bus.ram_we, bus.ram_addr, bus.ram_wdata};
    end

    // ---------------- reference model (operation level) ----------------
    logic [15:0] m_gpr [0:7];
    logic [15:0] m_ram [int];
    logic [15:0] m_opa, m_opb;

    // Each transfer costs (1 + wait) cycles, plus one DONE cycle.
    task automatic model_apply(input logic [2:0] op, rd, rs1, rs2, input logic [15:0] addr, imm, eu,
                               input int gw, rw, output int lat, output bit e, output int gc, output int rc);
        int ng, nr;
        ng = 0; nr = 0; e = 1'b0;
        case (op)
            3'd0: begin m_gpr[rd] = m_gpr[rs1]; ng = 2; end
            3'd1: begin m_gpr[rd] = imm; ng = 1; end
            3'd2: begin m_gpr[rd] = m_ram[int'(addr)]; ng = 1; nr = 1; end
            3'd3: begin m_ram[int'(addr)] = m_gpr[rs1]; ng = 1; nr = 1; end
            3'd4: begin m_opa = m_gpr[rs1]; m_opb = m_gpr[rs2]; ng = 2; end
            3'd5: begin m_gpr[rd] = eu; ng = 1; end
            default: e = 1'b1;
        endcase
        gc  = ng * (gw + 1);
        rc  = nr * (rw + 1);
        lat = 1 + gc + rc;
    endtask

    // ---------------- checking helpers ----------------
    int n_chk, n_err;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack_s();
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[i*16 +: 16] = s_gpr[i];
        return v;
    endfunction

    function automatic logic [127:0] pack_m();
        logic [127:0] v;
        for (int i = 0; i < 8; i++) v[i*16 +: 16] = m_gpr[i];
        return v;
    endfunction

    // Called just after a rising edge; returns cycles from start to done.
    task automatic exec(input logic [2:0] op, rd, rs1, rs2, input logic [15:0] addr, imm, eu,
                        input bit poke, output int lat, output bit e, output int gc, output int rc);
        op_i = op; rd_i = rd; rs1_i = rs1; rs2_i = rs2;
        mem_addr_i = addr; imm_i = imm; eu_result_i = eu; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        op_i = 3'($urandom); rd_i = 3'($urandom); rs1_i = 3'($urandom); rs2_i = 3'($urandom);
        mem_addr_i = 16'($urandom); imm_i = 16'($urandom); eu_result_i = 16'($urandom);
        lat = 1; gc = 0; rc = 0;
        while (done_o !== 1'b1 && lat < 100) begin
            gc += int'(bus.gpr_req);
            rc += int'(bus.ram_req);
            if (poke && lat == 1) begin
                start_i = 1'b1; op_i = 3'b001;
            end else begin
                start_i = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start_i = 1'b0;
        e = err_o;
        if (lat >= 100) begin
            n_chk++; n_err++;
            $display("FAIL done_wait: no done within %0d cycles", lat);
        end
        @(posedge clk); #1;
        chk("idle_after_done", {busy_o, done_o, err_o}, 0);
    endtask

    typedef struct {
        logic [2:0]  op, rd, rs1, rs2;
        logic [15:0] addr, imm, eu;
        int          gw, rw;
        bit          poke;
        int          lat;
        bit          err;
        int          gc, rc;
        int          kind;   // 0 none, 1 gpr[rd], 2 ram[addr], 3 op_a/op_b
        logic [15:0] v1, v2;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] op, rd, rs1, rs2, input logic [15:0] addr, imm, eu,
                                input int gw, rw, input bit poke, input int lat, input bit err,
                                input int gc, rc, kind, input logic [15:0] v1, v2);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.addr = addr; v.imm = imm; v.eu = eu;
        v.gw = gw; v.rw = rw; v.poke = poke; v.lat = lat; v.err = err; v.gc = gc; v.rc = rc;
        v.kind = kind; v.v1 = v1; v.v2 = v2;
        return v;
    endfunction

    vec_t tbl [15];

    initial begin
        int          lat, gc, rc, elat, egc, erc;
        bit          e, ee, seen;
        logic [2:0]  op, rd, rs1, rs2;
        logic [15:0] addr, imm, eu;
        bit          poke;

        n_chk = 0; n_err = 0;
        rst = 1'b1; start_i = 1'b0; op_i = '0; rd_i = '0; rs1_i = '0; rs2_i = '0;
        mem_addr_i = '0; imm_i = '0; eu_result_i = '0;
        gpr_wait = 0; ram_wait = 0; gpr_never = 1'b0; ram_never = 1'b0;
        bd_we = 1'b0; bd_ga = '0; bd_gd = '0; bd_ra = '0; bd_rd = '0;
        m_opa = '0; m_opb = '0;

        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", {busy_o, done_o, err_o, op_a_o, op_b_o,
                              bus.gpr_req, bus.gpr_we, bus.gpr_addr, bus.gpr_wdata,
                              bus.ram_req, bus.ram_we, bus.ram_addr, bus.ram_wdata}, 0);

        for (int i = 0; i < 8; i++) begin
            bd_we = 1'b1; bd_ga = 3'(i); bd_gd = 16'($urandom); bd_ra = 16'(i); bd_rd = 16'($urandom);
            m_gpr[i] = bd_gd; m_ram[i] = bd_rd;
            @(posedge clk); #1;
        end
        bd_we = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;

        //              op    rd    rs1   rs2   addr      imm       eu        gw rw pk lat err gc rc k  v1        v2
        tbl[0]  = mk(3'd1, 3'd3, 3'd0, 3'd0, 16'h0000, 16'hA5A5, 16'h0000, 0, 0, 0, 2, 0, 1, 0, 1, 16'hA5A5, 16'h0);
        tbl[1]  = mk(3'd7, 3'd3, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 0, 0, 0, 16'h0000, 16'h0);
        tbl[2]  = mk(3'd1, 3'd1, 3'd0, 3'd0, 16'h0000, 16'h0012, 16'h0000, 1, 0, 0, 3, 0, 2, 0, 1, 16'h0012, 16'h0);
        tbl[3]  = mk(3'd1, 3'd2, 3'd0, 3'd0, 16'h0000, 16'h0034, 16'h0000, 0, 0, 0, 2, 0, 1, 0, 1, 16'h0034, 16'h0);
        tbl[4]  = mk(3'd4, 3'd0, 3'd1, 3'd2, 16'h0000, 16'h0000, 16'h0000, 2, 0, 0, 7, 0, 6, 0, 3, 16'h0012, 16'h0034);
        tbl[5]  = mk(3'd1, 3'd6, 3'd0, 3'd0, 16'h0000, 16'hBEEF, 16'h0000, 0, 0, 0, 2, 0, 1, 0, 1, 16'hBEEF, 16'h0);
        tbl[6]  = mk(3'd3, 3'd0, 3'd6, 3'd0, 16'h0100, 16'h0000, 16'h0000, 0, 1, 0, 4, 0, 1, 2, 2, 16'hBEEF, 16'h0);
        tbl[7]  = mk(3'd2, 3'd5, 3'd0, 3'd0, 16'h0100, 16'h0000, 16'h0000, 0, 0, 1, 3, 0, 1, 1, 1, 16'hBEEF, 16'h0);
        tbl[8]  = mk(3'd3, 3'd0, 3'd5, 3'd0, 16'h0200, 16'h0000, 16'h0000, 0, 0, 1, 3, 0, 1, 1, 2, 16'hBEEF, 16'h0);
        tbl[9]  = mk(3'd0, 3'd4, 3'd3, 3'd0, 16'h0000, 16'h0000, 16'h0000, 3, 0, 0, 9, 0, 8, 0, 1, 16'hA5A5, 16'h0);
        tbl[10] = mk(3'd0, 3'd3, 3'd3, 3'd0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 3, 0, 2, 0, 1, 16'hA5A5, 16'h0);
        tbl[11] = mk(3'd5, 3'd7, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h1234, 0, 0, 0, 2, 0, 1, 0, 1, 16'h1234, 16'h0);
        tbl[12] = mk(3'd6, 3'd0, 3'd0, 3'd0, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 1, 1, 0, 0, 0, 16'h0000, 16'h0);
        tbl[13] = mk(3'd4, 3'd0, 3'd7, 3'd4, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 3, 0, 2, 0, 3, 16'h1234, 16'hA5A5);
        tbl[14] = mk(3'd2, 3'd0, 3'd0, 3'd0, 16'h0200, 16'h0000, 16'h0000, 0, 2, 0, 5, 0, 1, 3, 1, 16'hBEEF, 16'h0);

        for (int i = 0; i < 15; i++) begin
            gpr_wait = tbl[i].gw; ram_wait = tbl[i].rw;
            exec(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].addr, tbl[i].imm, tbl[i].eu,
                 tbl[i].poke, lat, e, gc, rc);
            model_apply(tbl[i].op, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].addr, tbl[i].imm, tbl[i].eu,
                        tbl[i].gw, tbl[i].rw, elat, ee, egc, erc);
            chk($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
            chk($sformatf("vec%0d_err", i), e, tbl[i].err);
            chk($sformatf("vec%0d_gpr_req_cycles", i), gc, tbl[i].gc);
            chk($sformatf("vec%0d_ram_req_cycles", i), rc, tbl[i].rc);
            case (tbl[i].kind)
                1: chk($sformatf("vec%0d_gpr_value", i), s_gpr[tbl[i].rd], tbl[i].v1);
                2: chk($sformatf("vec%0d_ram_value", i), s_ram[tbl[i].addr], tbl[i].v1);
                3: chk($sformatf("vec%0d_operands", i), {op_a_o, op_b_o}, {tbl[i].v1, tbl[i].v2});
                default: ;
            endcase
        end
        chk("table_gpr_state", pack_s(), pack_m());
        chk("table_ram_state", {s_ram[16'h0100], s_ram[16'h0200]}, {m_ram[32'h100], m_ram[32'h200]});

        // RAM never acks: request held TIMEOUT cycles, then abort with err.
        gpr_wait = 0; ram_wait = 0; ram_never = 1'b1;
        exec(3'd2, 3'd2, 3'd0, 3'd0, 16'h0003, 16'h0, 16'h0, 1'b0, lat, e, gc, rc);
        ram_never = 1'b0;
        chk("ram_timeout_latency", lat, 17);
        chk("ram_timeout_err", e, 1);
        chk("ram_timeout_req_cycles", {gc, rc}, {32'd0, 32'd16});
        chk("ram_timeout_gpr_untouched", pack_s(), pack_m());

        // GPR never acks during FETCH2: operands must keep their old values.
        gpr_never = 1'b1;
        exec(3'd4, 3'd0, 3'd1, 3'd2, 16'h0, 16'h0, 16'h0, 1'b0, lat, e, gc, rc);
        gpr_never = 1'b0;
        chk("gpr_timeout_latency", lat, 17);
        chk("gpr_timeout_err", e, 1);
        chk("gpr_timeout_req_cycles", gc, 16);
        chk("gpr_timeout_operands_held", {op_a_o, op_b_o}, {m_opa, m_opb});

        // Asynchronous reset in the middle of a stalled LOAD.
        ram_never = 1'b1;
        op_i = 3'd2; rd_i = 3'd5; mem_addr_i = 16'h0100; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mid_load_ram_req", bus.ram_req, 1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_async_drop", {bus.ram_req, bus.gpr_req, busy_o, done_o, err_o}, 0);
        @(posedge clk); #1;
        rst = 1'b0; ram_never = 1'b0;
        m_opa = '0; m_opb = '0;
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (done_o || busy_o) seen = 1'b1;
        end
        chk("rst_no_done_after", seen, 0);
        chk("rst_gpr_untouched", pack_s(), pack_m());

        // Random operations against the model.
        for (int k = 0; k < 40; k++) begin
            op = 3'($urandom_range(0, 7)); rd = 3'($urandom); rs1 = 3'($urandom); rs2 = 3'($urandom);
            addr = 16'($urandom_range(0, 7)); imm = 16'($urandom); eu = 16'($urandom);
            gpr_wait = $urandom_range(0, 3); ram_wait = $urandom_range(0, 3);
            poke = 1'($urandom);
            exec(op, rd, rs1, rs2, addr, imm, eu, poke, lat, e, gc, rc);
            model_apply(op, rd, rs1, rs2, addr, imm, eu, gpr_wait, ram_wait, elat, ee, egc, erc);
            chk($sformatf("rnd%0d_op%0d_latency", k, op), lat, elat);
            chk($sformatf("rnd%0d_op%0d_err", k, op), e, ee);
            chk($sformatf("rnd%0d_op%0d_req_cycles", k, op), {gc, rc}, {egc, erc});
            chk($sformatf("rnd%0d_op%0d_operands", k, op), {op_a_o, op_b_o}, {m_opa, m_opb});
            chk($sformatf("rnd%0d_op%0d_gpr_state", k, op), pack_s(), pack_m());
            chk($sformatf("rnd%0d_op%0d_ram_value", k, op), s_ram[addr], m_ram[int'(addr)]);
        end

        chk("protocol_violations", proto_err, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
